// File: rtl/xlr8_pin_mode_seq.sv
// xlr8_pin_mode_seq: per-pin digital/analog mode sequencer for A0..A(N-1).
// Switching pins are broken (OE, pullup, analog switch all off) for one
// cycle, held disconnected while a settle counter runs, then committed.
// Pad inputs are synchronised and masked on analog pins; the board I2C
// pullup enable is gated by the mode of the last two pins (SDA, SCL).
// Optional feature macro: XLR8_PIN_GLITCH_FILTER_EN adds a 3-sample
// majority filter behind the input synchroniser.
module xlr8_pin_mode_seq #(
  parameter int NUM_PINS      = 6,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                Clock,
  input  logic                RESET,
  input  logic [NUM_PINS-1:0] mode_req,
  input  logic                mode_req_valid,
  output logic                mode_req_ready,
  output logic [NUM_PINS-1:0] mode_cur,
  output logic                mode_done,
  output logic                busy,
  input  logic [NUM_PINS-1:0] dig_oe_in,
  input  logic [NUM_PINS-1:0] dig_out_in,
  input  logic [NUM_PINS-1:0] pullup_req,
  input  logic [NUM_PINS-1:0] pad_in,
  output logic [NUM_PINS-1:0] pad_oe,
  output logic [NUM_PINS-1:0] pad_out,
  output logic [NUM_PINS-1:0] pullup_en,
  output logic [NUM_PINS-1:0] ana_connect,
  output logic [NUM_PINS-1:0] dig_in,
  input  logic                i2c_pull_req,
  output logic                I2C_ENABLE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BREAK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

  state_t              state_r;
  logic [NUM_PINS-1:0] req_r;
  logic [NUM_PINS-1:0] chg_r;
  logic [NUM_PINS-1:0] mode_cur_r;
  logic [7:0]          cnt_r;
  logic                mode_done_r;

  logic                accept_s;
  logic                busy_s;
  logic                exit_s;
  logic [NUM_PINS-1:0] mode_nxt_s;
  logic [NUM_PINS-1:0] oe_nxt_s;
  logic [NUM_PINS-1:0] out_nxt_s;
  logic [NUM_PINS-1:0] pu_nxt_s;
  logic [NUM_PINS-1:0] ana_nxt_s;
  logic                i2c_nxt_s;
  logic [NUM_PINS-1:0] sync_r [0:SYNC_STAGES-2];
  logic [NUM_PINS-1:0] sync_out_s;
  logic [NUM_PINS-1:0] din_src_s;

  assign busy_s         = (state_r != ST_IDLE);
  assign accept_s       = mode_req_valid & (state_r == ST_IDLE);
  assign exit_s         = (state_r == ST_SETTLE) & (cnt_r == SETTLE_LAST);
  assign mode_req_ready = (state_r == ST_IDLE) & ~RESET;
  assign busy           = busy_s;
  assign mode_cur       = mode_cur_r;
  assign mode_done      = mode_done_r;
  assign sync_out_s     = sync_r[SYNC_STAGES-2];

  // Sequencer FSM: accept request, break, settle, commit mode_cur.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      req_r       <= '1;
      chg_r       <= '0;
      cnt_r       <= 8'd0;
      mode_cur_r  <= '1;
      mode_done_r <= 1'b0;
    end else begin
      mode_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            req_r <= mode_req;
            chg_r <= mode_req ^ mode_cur_r;
            if (mode_req == mode_cur_r) begin
              mode_done_r <= 1'b1;
            end else begin
              state_r <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          cnt_r   <= 8'd0;
          state_r <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            mode_cur_r  <= req_r;
            mode_done_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Mode that mode_cur will hold after this edge (used to mask dig_in).
  always_comb begin
    mode_nxt_s = mode_cur_r;
    if (exit_s) begin
      mode_nxt_s = req_r;
    end else begin
      mode_nxt_s = mode_cur_r;
    end
  end

  // Per-pin pad drive: switching pins isolated while busy, else by mode.
  always_comb begin
    oe_nxt_s  = '0;
    out_nxt_s = '0;
    pu_nxt_s  = '0;
    ana_nxt_s = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (busy_s && chg_r[i]) begin
        oe_nxt_s[i]  = 1'b0;
        out_nxt_s[i] = 1'b0;
        pu_nxt_s[i]  = 1'b0;
        ana_nxt_s[i] = 1'b0;
      end else if (mode_cur_r[i]) begin
        oe_nxt_s[i]  = 1'b0;
        out_nxt_s[i] = 1'b0;
        pu_nxt_s[i]  = 1'b0;
        ana_nxt_s[i] = 1'b1;
      end else begin
        oe_nxt_s[i]  = dig_oe_in[i];
        out_nxt_s[i] = dig_out_in[i];
        pu_nxt_s[i]  = pullup_req[i];
        ana_nxt_s[i] = 1'b0;
      end
    end
  end

  assign i2c_nxt_s = i2c_pull_req & ~mode_cur_r[NUM_PINS-2] & ~mode_cur_r[NUM_PINS-1]
                     & ~(busy_s & (chg_r[NUM_PINS-2] | chg_r[NUM_PINS-1]));

  // Registered pad and I2C pullup outputs.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      pad_oe      <= '0;
      pad_out     <= '0;
      pullup_en   <= '0;
      ana_connect <= '1;
      I2C_ENABLE  <= 1'b0;
    end else begin
      pad_oe      <= oe_nxt_s;
      pad_out     <= out_nxt_s;
      pullup_en   <= pu_nxt_s;
      ana_connect <= ana_nxt_s;
      I2C_ENABLE  <= i2c_nxt_s;
    end
  end

  // Input synchroniser; the final stage is the dig_in register below.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      for (int k = 0; k < SYNC_STAGES - 1; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES - 1; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

`ifdef XLR8_PIN_GLITCH_FILTER_EN
  logic [NUM_PINS-1:0] hist0_r;
  logic [NUM_PINS-1:0] hist1_r;
  logic [NUM_PINS-1:0] hist2_r;
  logic [NUM_PINS-1:0] entry_s;

  // Pins switching into digital mode on this edge start with clean history.
  assign entry_s = chg_r & ~req_r & {NUM_PINS{exit_s}};

  // Three-sample history for the majority filter.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      hist0_r <= '0;
      hist1_r <= '0;
      hist2_r <= '0;
    end else begin
      hist0_r <= sync_out_s & ~entry_s;
      hist1_r <= hist0_r & ~entry_s;
      hist2_r <= hist1_r & ~entry_s;
    end
  end

  assign din_src_s = (hist0_r & hist1_r) | (hist0_r & hist2_r) | (hist1_r & hist2_r);
`else
  assign din_src_s = sync_out_s;
`endif

  // Registered digital input, forced to zero on analog pins.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      dig_in <= '0;
    end else begin
      dig_in <= din_src_s & ~mode_nxt_s;
    end
  end

endmodule

// File: tb/tb_xlr8_pin_mode_seq.sv
// Self-checking bench for xlr8_pin_mode_seq (6 pins, settle 16, sync 2).
module tb_xlr8_pin_mode_seq;

  localparam int N = 6;
`ifdef XLR8_PIN_GLITCH_FILTER_EN
  localparam int   LAT       = 4;
  localparam logic GLITCH_EXP = 1'b0;
`else
  localparam int   LAT       = 2;
  localparam logic GLITCH_EXP = 1'b1;
`endif

  logic         Clock = 1'b0;
  logic         RESET;
  logic [N-1:0] mode_req;
  logic         mode_req_valid;
  logic         mode_req_ready;
  logic [N-1:0] mode_cur;
  logic         mode_done;
  logic         busy;
  logic [N-1:0] dig_oe_in;
  logic [N-1:0] dig_out_in;
  logic [N-1:0] pullup_req;
  logic [N-1:0] pad_in;
  logic [N-1:0] pad_oe;
  logic [N-1:0] pad_out;
  logic [N-1:0] pullup_en;
  logic [N-1:0] ana_connect;
  logic [N-1:0] dig_in;
  logic         i2c_pull_req;
  logic         I2C_ENABLE;

  always #5 Clock = ~Clock;

  xlr8_pin_mode_seq #(.NUM_PINS(N), .SETTLE_CYCLES(16), .SYNC_STAGES(2)) dut (
    .Clock(Clock), .RESET(RESET),
    .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
    .mode_cur(mode_cur), .mode_done(mode_done), .busy(busy),
    .dig_oe_in(dig_oe_in), .dig_out_in(dig_out_in), .pullup_req(pullup_req), .pad_in(pad_in),
    .pad_oe(pad_oe), .pad_out(pad_out), .pullup_en(pullup_en), .ana_connect(ana_connect),
    .dig_in(dig_in), .i2c_pull_req(i2c_pull_req), .I2C_ENABLE(I2C_ENABLE)
  );

  typedef struct {
    logic [N-1:0] oe;
    logic [N-1:0] dout;
    logic [N-1:0] pu;
    logic         i2c;
    logic [N-1:0] pin;
    logic [N-1:0] e_oe;
    logic [N-1:0] e_out;
    logic [N-1:0] e_pu;
    logic         e_i2c;
    logic [N-1:0] e_din;
  } vec_t;

  vec_t tbl [6];
  vec_t exp_q [$];
  logic oe_q [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic run_req(input logic [N-1:0] r, input int exp_lat, input string name);
    int c;
    mode_req = r;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    c = 0;
    while (mode_done !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    chk(name, c, exp_lat);
    step();
  endtask

  initial begin
    int   c;
    logic seen;
    vec_t e;
    logic eb;

    // Steady-state vectors with mode_cur = 6'h0C (pins 2,3 analog).
    tbl[0] = '{6'h3F, 6'h15, 6'h00, 1'b1, 6'h3F, 6'h33, 6'h11, 6'h00, 1'b1, 6'h33};
    tbl[1] = '{6'h00, 6'h3F, 6'h3F, 1'b0, 6'h00, 6'h00, 6'h33, 6'h33, 1'b0, 6'h00};
    tbl[2] = '{6'h2A, 6'h0C, 6'h15, 1'b1, 6'h0C, 6'h22, 6'h00, 6'h11, 1'b1, 6'h00};
    tbl[3] = '{6'h15, 6'h2A, 6'h2A, 1'b1, 6'h2D, 6'h11, 6'h22, 6'h22, 1'b1, 6'h21};
    tbl[4] = '{6'h0C, 6'h0C, 6'h0C, 1'b0, 6'h12, 6'h00, 6'h00, 6'h00, 1'b0, 6'h12};
    tbl[5] = '{6'h21, 6'h12, 6'h30, 1'b1, 6'h33, 6'h21, 6'h12, 6'h30, 1'b1, 6'h33};

    RESET = 1'b1; mode_req = '1; mode_req_valid = 1'b0;
    dig_oe_in = '0; dig_out_in = '0; pullup_req = '0; pad_in = 6'h3F; i2c_pull_req = 1'b1;

    // 1: reset state
    step(); step();
    chk("rst_ready", mode_req_ready, 1'b0);
    chk("rst_ana", ana_connect, 6'h3F);
    chk("rst_mode_cur", mode_cur, 6'h3F);
    chk("rst_pad_oe", pad_oe, 6'h00);
    chk("rst_i2c", I2C_ENABLE, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", mode_done, 1'b0);
    chk("rst_dig_in", dig_in, 6'h00);
    RESET = 1'b0; pad_in = '0; i2c_pull_req = 1'b0;
    step();
    chk("ready_after_rst", mode_req_ready, 1'b1);

    // 2: all digital, break/settle timing
    dig_oe_in = 6'h05;
    mode_req = 6'h00; mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    chk("t2_busy_c0", busy, 1'b1);
    chk("t2_ready_c0", mode_req_ready, 1'b0);
    step();
    chk("t2_ana_c1", ana_connect, 6'h00);
    chk("t2_oe_c1", pad_oe, 6'h00);
    c = 1;
    while (mode_done !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    chk("t2_done_cycle", c, 18);
    chk("t2_mode_cur", mode_cur, 6'h00);
    chk("t2_oe_c18", pad_oe, 6'h00);
    step();
    chk("t2_oe_c19", pad_oe, 6'h05);
    chk("t2_done_c19", mode_done, 1'b0);

    // table: steady-state pass-through at mode 6'h0C
    run_req(6'h0C, 18, "lat_0c");
    foreach (tbl[i]) begin
      dig_oe_in = tbl[i].oe; dig_out_in = tbl[i].dout;
      pullup_req = tbl[i].pu; i2c_pull_req = tbl[i].i2c;
      exp_q.push_back(tbl[i]);
      step();
      e = exp_q.pop_front();
      chk($sformatf("tbl%0d_oe", i), pad_oe, e.e_oe);
      chk($sformatf("tbl%0d_out", i), pad_out, e.e_out);
      chk($sformatf("tbl%0d_pu", i), pullup_en, e.e_pu);
      chk($sformatf("tbl%0d_i2c", i), I2C_ENABLE, e.e_i2c);
      chk($sformatf("tbl%0d_ana", i), ana_connect, 6'h0C);
    end
    foreach (tbl[i]) begin
      pad_in = tbl[i].pin;
      exp_q.push_back(tbl[i]);
      repeat (LAT) step();
      e = exp_q.pop_front();
      chk($sformatf("tbl%0d_din", i), dig_in, e.e_din);
    end
    pad_in = '0; dig_out_in = '0; pullup_req = '0; i2c_pull_req = 1'b0;

    // 3: pin0 to analog while pin1 OE toggles through
    dig_oe_in = 6'h03;
    run_req(6'h00, 18, "lat_00");
    chk("t3_pre_oe", pad_oe, 6'h03);
    mode_req = 6'h01; mode_req_valid = 1'b1;
    oe_q.push_back(dig_oe_in[1]);
    step();
    mode_req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      eb = oe_q.pop_front();
      chk($sformatf("t3_pin1_c%0d", k), pad_oe[1], eb);
      if (k >= 1) chk($sformatf("t3_pin0_c%0d", k), pad_oe[0], 1'b0);
      if (k == 18) chk("t3_done_c18", mode_done, 1'b1);
      if (k == 19) chk("t3_ana0_c19", ana_connect[0], 1'b1);
      dig_oe_in[1] = ~dig_oe_in[1];
      oe_q.push_back(dig_oe_in[1]);
      step();
    end
    oe_q.delete();

    // 4: request while busy is held off until IDLE
    mode_req = 6'h00; mode_req_valid = 1'b1;
    step();
    mode_req = 6'h10;
    chk("t4_ready_busy", mode_req_ready, 1'b0);
    c = 0;
    while (mode_done !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    chk("t4_done_cycle", c, 18);
    chk("t4_mode_first", mode_cur, 6'h00);
    chk("t4_ready_idle", mode_req_ready, 1'b1);
    step();
    mode_req_valid = 1'b0;
    chk("t4_busy_second", busy, 1'b1);
    c = 0;
    while (mode_done !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    chk("t4_done2_cycle", c, 18);
    chk("t4_mode_second", mode_cur, 6'h10);
    step();

    // 5: reset in the middle of SETTLE
    mode_req = 6'h00; mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    repeat (5) step();
    chk("t5_busy_c5", busy, 1'b1);
    RESET = 1'b1;
    step();
    chk("t5_mode_cur", mode_cur, 6'h3F);
    chk("t5_ana", ana_connect, 6'h3F);
    chk("t5_oe", pad_oe, 6'h00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ready", mode_req_ready, 1'b0);
    RESET = 1'b0;
    seen = mode_done;
    repeat (25) begin
      step();
      seen = seen | mode_done;
    end
    chk("t5_no_done", seen, 1'b0);
    mode_req = 6'h3F; mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    chk("t5_noop_done", mode_done, 1'b1);
    chk("t5_noop_busy", busy, 1'b0);
    step();
    chk("t5_done_pulse", mode_done, 1'b0);

    // 6: I2C pullup gating and input glitch handling
    i2c_pull_req = 1'b1; pad_in = '0;
    run_req(6'h00, 18, "lat_i2c");
    chk("t6_i2c_on", I2C_ENABLE, 1'b1);
    mode_req = 6'h20; mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    chk("t6_i2c_c0", I2C_ENABLE, 1'b1);
    step();
    chk("t6_i2c_c1", I2C_ENABLE, 1'b0);
    c = 1;
    while (mode_done !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    chk("t6_done_cycle", c, 18);
    step();
    chk("t6_i2c_after", I2C_ENABLE, 1'b0);
    chk("t6_mode_cur", mode_cur, 6'h20);
    repeat (6) step();
    pad_in[0] = 1'b1;
    step();
    pad_in[0] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      step();
      seen = seen | dig_in[0];
    end
    chk("t6_pulse1", seen, GLITCH_EXP);
    seen = 1'b0;
    pad_in[0] = 1'b1;
    repeat (3) begin
      step();
      seen = seen | dig_in[0];
    end
    pad_in[0] = 1'b0;
    repeat (8) begin
      step();
      seen = seen | dig_in[0];
    end
    chk("t6_pulse3", seen, 1'b1);
    pad_in = 6'h20;
    repeat (6) step();
    chk("t6_analog_din", dig_in, 6'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
